// File: rtl/mux_scan_ctrl_if.sv
// Select/sample bus between the scan sequencer and its 4:1 mux.
// Also carries the scan control inputs and the reassembled word.
interface mux_scan_ctrl_if;
    logic       start;
    logic       mode;
    logic       abort;
    logic       mux_out;
    logic [1:0] sel;
    logic       busy;
    logic [3:0] word;
    logic       word_valid;

    modport master (
        output start, mode, abort, mux_out,
        input  sel, busy, word, word_valid
    );

    modport slave (
        input  start, mode, abort, mux_out,
        output sel, busy, word, word_valid
    );
endinterface

// File: rtl/mux_scan_ctrl.sv
// Steps a 4:1 mux select through 0..3 with a fixed dwell per input.
// Rebuilds the four inputs into a word, single-shot or continuous.
module mux_scan_ctrl #(
    parameter int DWELL = 2,
    parameter int CNT_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    mux_scan_ctrl_if.slave  bus
);
    typedef enum logic {IDLE, SCAN} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       shadow;
    logic             mode_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            shadow         <= '0;
            mode_q         <= 1'b0;
            bus.sel        <= 2'b00;
            bus.busy       <= 1'b0;
            bus.word       <= 4'b0000;
            bus.word_valid <= 1'b0;
        end else begin
            bus.word_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start && !bus.abort) begin
                        state    <= SCAN;
                        mode_q   <= bus.mode;
                        cnt      <= '0;
                        shadow   <= '0;
                        bus.sel  <= 2'b00;
                        bus.busy <= 1'b1;
                    end
                end
                SCAN: begin
                    if (bus.abort) begin
                        // abort beats a same-edge completion
                        state    <= IDLE;
                        cnt      <= '0;
                        shadow   <= '0;
                        bus.sel  <= 2'b00;
                        bus.busy <= 1'b0;
                    end else if (cnt == LAST) begin
                        cnt             <= '0;
                        shadow[bus.sel] <= bus.mux_out;
                        bus.sel         <= bus.sel + 2'd1;
                        if (bus.sel == 2'd3) begin
                            bus.word       <= {bus.mux_out, shadow[2:0]};
                            bus.word_valid <= 1'b1;
                            if (!mode_q) begin
                                state    <= IDLE;
                                bus.busy <= 1'b0;
                            end
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
